// File: rtl/bus_pkg.sv
// Shared definitions for the bus master port: field widths, rw encoding,
// FSM state type and the packed request entry held in the request FIFO.
package bus_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Request FIFO: power-of-two depth, wrapping pointers, occupancy count drives
// full/empty. Head entry is presented combinationally on pop_data.
module req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Core-side request queue feeding a single-outstanding bus master that
// requests arbitration, issues the head request and returns read data.
//
// state   | meaning
// IDLE    | no bus activity; move to REQ once the FIFO holds a request
// REQ     | bus_request high, head request driven; wait for bus_grant
// RD_WAIT | read granted; count down READ_LATENCY, then pulse resp_valid
module bus_master_port
  import bus_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              bus_request,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_rw,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY);

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  req_t             push_entry;
  req_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  assign req_ready  = !fifo_full;
  assign fifo_push  = req_valid && req_ready;
  assign push_entry = '{rw: req_rw, addr: req_addr, data: req_wdata};

  // Grants are only honoured while a request is actually on the bus.
  assign fifo_pop = (state == REQ) && bus_grant;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      bus_request <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      bus_rw      <= RW_READ;
      bus_address <= '0;
      bus_wdata   <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state       <= REQ;
            bus_request <= 1'b1;
            bus_rw      <= head.rw;
            bus_address <= head.addr;
            bus_wdata   <= head.data;
          end
        end
        REQ: begin
          if (bus_grant) begin
            bus_request <= 1'b0;
            if (head.rw == RW_WRITE) begin
              state <= IDLE;
            end else begin
              lat_cnt <= CNT_LOAD;
              state   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - CNT_ONE;
          // Last wait cycle: this edge is grant+READ_LATENCY, data is valid.
          if (lat_cnt == CNT_ONE) begin
            resp_valid <= 1'b1;
            resp_rdata <= bus_rdata;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
